// File: rtl/iob_dbus_bridge.sv
// IOb native responder bridging one transaction at a time onto a cmd/rsp data bus.
// Optional response watchdog: define IOB_DBUS_BRIDGE_TIMEOUT_EN.
module iob_dbus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]      iob_req,
  output logic [DATA_W:0]                      iob_resp,
  output logic                                 dbus_cmd_valid,
  input  logic                                 dbus_cmd_ready,
  output logic                                 dbus_cmd_wr,
  output logic [ADDR_W-1:0]                    dbus_cmd_address,
  output logic [DATA_W-1:0]                    dbus_cmd_data,
  output logic [DATA_W/8-1:0]                  dbus_cmd_mask,
  output logic [1:0]                           dbus_cmd_size,
  input  logic                                 dbus_rsp_valid,
  input  logic [DATA_W-1:0]                    dbus_rsp_data,
  input  logic                                 dbus_rsp_error,
  output logic                                 err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;

  // state | meaning
  // IDLE  | waiting for an IOb request
  // CMD   | command presented on dbus, waiting for cmd_ready
  // RSP   | read accepted, waiting for rsp_valid
  // DONE  | one-cycle IOb ready pulse
  typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

  state_t state, state_next;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  assign req_valid = iob_req[REQ_W-1];
  assign req_addr  = iob_req[ADDR_W+DATA_W+STRB_W-1 -: ADDR_W];
  assign req_wdata = iob_req[DATA_W+STRB_W-1 -: DATA_W];
  assign req_wstrb = iob_req[STRB_W-1:0];

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] mask_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic rsp_take;
  logic timeout_hit;

  function automatic logic [1:0] write_size(input logic [STRB_W-1:0] strb);
    int n;
    n = 0;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) n++;
    end
    if (n == 1)      return 2'd0;
    else if (n == 2) return 2'd1;
    else             return 2'd2;
  endfunction

`ifdef IOB_DBUS_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  logic [CNT_W-1:0] to_cnt;
  logic             stale;

  // A response that outlived its watchdog is swallowed once, whatever the state.
  assign rsp_take    = (state == RSP) && dbus_rsp_valid && !stale;
  assign timeout_hit = (state == RSP) && !rsp_take && (to_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      if (state == CMD)
        to_cnt <= CNT_W'(TIMEOUT);
      else if (state == RSP && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;

      if (timeout_hit)
        stale <= 1'b1;
      else if (stale && dbus_rsp_valid)
        stale <= 1'b0;
    end
  end
`else
  assign rsp_take    = (state == RSP) && dbus_rsp_valid;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = CMD;
      CMD:  if (dbus_cmd_ready) state_next = wr_q ? DONE : RSP;
      RSP:  if (rsp_take || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        data_q <= req_wdata;
        wr_q   <= |req_wstrb;
        mask_q <= (|req_wstrb) ? req_wstrb : '1;
        size_q <= (|req_wstrb) ? write_size(req_wstrb) : 2'd2;
      end

      if (rsp_take)
        rdata_q <= dbus_rsp_data;
`ifdef IOB_DBUS_BRIDGE_TIMEOUT_EN
      else if (timeout_hit)
        rdata_q <= TIMEOUT_DATA;
`endif

      if ((rsp_take && dbus_rsp_error) || timeout_hit)
        err_q <= 1'b1;
    end
  end

  assign dbus_cmd_valid   = (state == CMD);
  assign dbus_cmd_wr      = wr_q;
  assign dbus_cmd_address = addr_q;
  assign dbus_cmd_data    = data_q;
  assign dbus_cmd_mask    = mask_q;
  assign dbus_cmd_size    = size_q;
  assign iob_resp         = {rdata_q, (state == DONE)};
  assign err              = err_q;

endmodule

// File: tb/tb_iob_dbus_bridge.sv
// Directed self-checking bench for iob_dbus_bridge.
module tb_iob_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [68:0] iob_req;
  logic [32:0] iob_resp;
  logic        dbus_cmd_valid;
  logic        dbus_cmd_ready;
  logic        dbus_cmd_wr;
  logic [31:0] dbus_cmd_address;
  logic [31:0] dbus_cmd_data;
  logic [3:0]  dbus_cmd_mask;
  logic [1:0]  dbus_cmd_size;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rsp_data;
  logic        dbus_rsp_error;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rdata;

  assign iob_req = {valid, addr, wdata, wstrb};

  always #5 clk = ~clk;

  iob_dbus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .iob_req          (iob_req),
    .iob_resp         (iob_resp),
    .dbus_cmd_valid   (dbus_cmd_valid),
    .dbus_cmd_ready   (dbus_cmd_ready),
    .dbus_cmd_wr      (dbus_cmd_wr),
    .dbus_cmd_address (dbus_cmd_address),
    .dbus_cmd_data    (dbus_cmd_data),
    .dbus_cmd_mask    (dbus_cmd_mask),
    .dbus_cmd_size    (dbus_cmd_size),
    .dbus_rsp_valid   (dbus_rsp_valid),
    .dbus_rsp_data    (dbus_rsp_data),
    .dbus_rsp_error   (dbus_rsp_error),
    .err              (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_size, input string tag);
    valid = 1'b1; addr = a; wdata = d; wstrb = s; dbus_cmd_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_cmd_valid"}, 64'(dbus_cmd_valid), 64'd1);
    chk({tag, "_wr"},        64'(dbus_cmd_wr), 64'd1);
    chk({tag, "_mask"},      64'(dbus_cmd_mask), 64'(s));
    chk({tag, "_size"},      64'(dbus_cmd_size), 64'(exp_size));
    chk({tag, "_addr"},      64'(dbus_cmd_address), 64'(a));
    chk({tag, "_data"},      64'(dbus_cmd_data), 64'(d));
    chk({tag, "_early_rdy"}, 64'(iob_resp[0]), 64'd0);
    @(negedge clk);
    chk({tag, "_ready"},     64'(iob_resp[0]), 64'd1);
    chk({tag, "_cmd_off"},   64'(dbus_cmd_valid), 64'd0);
    chk({tag, "_rdata_kept"}, 64'(iob_resp[32:1]), 64'(last_rdata));
    valid = 1'b0; dbus_cmd_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_1cyc"}, 64'(iob_resp[0]), 64'd0);
  endtask

  task automatic read_txn(input logic [31:0] a, input int stall, input int gap,
                          input logic [31:0] d, input logic e, input logic exp_err,
                          input string tag);
    valid = 1'b1; addr = a; wdata = 32'h0; wstrb = 4'h0; dbus_cmd_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_stall_valid"}, 64'(dbus_cmd_valid), 64'd1);
      chk({tag, "_stall_addr"},  64'(dbus_cmd_address), 64'(a));
      chk({tag, "_stall_mask"},  64'(dbus_cmd_mask), 64'hF);
      @(negedge clk);
    end
    chk({tag, "_cmd_valid"}, 64'(dbus_cmd_valid), 64'd1);
    chk({tag, "_wr"},        64'(dbus_cmd_wr), 64'd0);
    chk({tag, "_mask"},      64'(dbus_cmd_mask), 64'hF);
    chk({tag, "_size"},      64'(dbus_cmd_size), 64'd2);
    chk({tag, "_addr"},      64'(dbus_cmd_address), 64'(a));
    dbus_cmd_ready = 1'b1;
    @(negedge clk);
    dbus_cmd_ready = 1'b0;
    chk({tag, "_cmd_off"}, 64'(dbus_cmd_valid), 64'd0);
    for (int i = 0; i < gap; i++) begin
      chk({tag, "_wait_rdy"}, 64'(iob_resp[0]), 64'd0);
      @(negedge clk);
    end
    dbus_rsp_valid = 1'b1; dbus_rsp_data = d; dbus_rsp_error = e;
    @(negedge clk);
    chk({tag, "_ready"}, 64'(iob_resp[0]), 64'd1);
    chk({tag, "_rdata"}, 64'(iob_resp[32:1]), 64'(d));
    chk({tag, "_err"},   64'(err), 64'(exp_err));
    last_rdata = d;
    dbus_rsp_valid = 1'b0; dbus_rsp_error = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_1cyc"}, 64'(iob_resp[0]), 64'd0);
    chk({tag, "_rdata_hold"}, 64'(iob_resp[32:1]), 64'(d));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    dbus_cmd_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_data = '0; dbus_rsp_error = 1'b0;
    last_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", 64'(dbus_cmd_valid), 64'd0);
    chk("rst_cmd_fields", 64'({dbus_cmd_wr, dbus_cmd_mask, dbus_cmd_size}), 64'd0);
    chk("rst_cmd_addr", 64'(dbus_cmd_address), 64'd0);
    chk("rst_cmd_data", 64'(dbus_cmd_data), 64'd0);
    chk("rst_resp", 64'(iob_resp), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    write_txn(32'h100, 32'h12345678, 4'hF, 2'd2, "wr_word");
    write_txn(32'h102, 32'h00AB0000, 4'h4, 2'd0, "wr_byte");
    write_txn(32'h102, 32'hBEEF0000, 4'hC, 2'd1, "wr_half");

    read_txn(32'h200, 3, 1, 32'hCAFEF00D, 1'b0, 1'b0, "rd_bp");

    // response with nothing outstanding must not touch rdata
    dbus_rsp_valid = 1'b1; dbus_rsp_data = 32'h11111111;
    @(negedge clk);
    dbus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_rdata", 64'(iob_resp[32:1]), 64'hCAFEF00D);
    chk("stray_ready", 64'(iob_resp[0]), 64'd0);

    // valid held through DONE, then a new read presented right after
    valid = 1'b1; addr = 32'h300; wdata = 32'hA5A5A5A5; wstrb = 4'hF; dbus_cmd_ready = 1'b1;
    @(negedge clk);
    chk("held_cmd_valid", 64'(dbus_cmd_valid), 64'd1);
    @(negedge clk);
    chk("held_ready", 64'(iob_resp[0]), 64'd1);
    @(negedge clk);
    chk("held_no_dup", 64'(dbus_cmd_valid), 64'd0);
    chk("held_ready_off", 64'(iob_resp[0]), 64'd0);
    addr = 32'h304; wdata = 32'h0; wstrb = 4'h0;
    @(negedge clk);
    chk("b2b_cmd_valid", 64'(dbus_cmd_valid), 64'd1);
    chk("b2b_wr", 64'(dbus_cmd_wr), 64'd0);
    chk("b2b_addr", 64'(dbus_cmd_address), 64'h304);
    @(negedge clk);
    chk("b2b_in_rsp", 64'(dbus_cmd_valid), 64'd0);
    dbus_cmd_ready = 1'b0; dbus_rsp_valid = 1'b1; dbus_rsp_data = 32'h13579BDF;
    @(negedge clk);
    chk("b2b_ready", 64'(iob_resp[0]), 64'd1);
    chk("b2b_rdata", 64'(iob_resp[32:1]), 64'h13579BDF);
    last_rdata = 32'h13579BDF;
    valid = 1'b0; dbus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("b2b_ready_off", 64'(iob_resp[0]), 64'd0);

    read_txn(32'h600, 0, 0, 32'h0000BEEF, 1'b1, 1'b1, "rd_err");
    write_txn(32'h604, 32'h01020304, 4'h3, 2'd1, "wr_after_err");
    read_txn(32'h608, 0, 2, 32'h87654321, 1'b0, 1'b1, "rd_after_err");
    chk("err_sticky", 64'(err), 64'd1);

    // reset while a read is outstanding
    valid = 1'b1; addr = 32'h400; wstrb = 4'h0; dbus_cmd_ready = 1'b0;
    @(negedge clk);
    dbus_cmd_ready = 1'b1;
    @(negedge clk);
    dbus_cmd_ready = 1'b0;
    chk("mid_in_rsp", 64'(dbus_cmd_valid), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cmd", 64'({dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_mask, dbus_cmd_size}), 64'd0);
    chk("mid_rst_addr", 64'(dbus_cmd_address), 64'd0);
    chk("mid_rst_resp", 64'(iob_resp), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'({dbus_cmd_valid, iob_resp[0]}), 64'd0);
    last_rdata = 32'h0;
    write_txn(32'h700, 32'hFFEEDDCC, 4'h1, 2'd0, "post_rst_wr");
    chk("post_rst_err", 64'(err), 64'd0);

`ifdef IOB_DBUS_BRIDGE_TIMEOUT_EN
    begin
      int n;
      valid = 1'b1; addr = 32'h500; wstrb = 4'h0; dbus_cmd_ready = 1'b0;
      @(negedge clk);
      dbus_cmd_ready = 1'b1;
      @(negedge clk);
      dbus_cmd_ready = 1'b0;
      n = 0;
      while (!iob_resp[0] && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("to_ready_seen", 64'(iob_resp[0]), 64'd1);
      chk("to_not_early", 64'(n >= 8), 64'd1);
      chk("to_rdata", 64'(iob_resp[32:1]), 64'hDEADBEEF);
      chk("to_err", 64'(err), 64'd1);
      valid = 1'b0;
      @(negedge clk);
      dbus_rsp_valid = 1'b1; dbus_rsp_data = 32'h55555555;
      @(negedge clk);
      dbus_rsp_valid = 1'b0;
      chk("to_late_discard", 64'(iob_resp[32:1]), 64'hDEADBEEF);
      @(negedge clk);
      read_txn(32'h504, 0, 0, 32'h2468ACE0, 1'b0, 1'b1, "to_next_rd");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iob_dbus_bridge.md
# iob_dbus_bridge

IOb-native responder that bridges requests from an IOb initiator onto a VexRiscv-style simple data bus (cmd/rsp). It serves as the responder end of the IOb native request/response interface, so masters on the interconnect can reach peripherals that only expose a cmd/rsp port. It holds one transaction in flight, registers all request fields, and returns a single-cycle IOb `ready` pulse with read data.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `TIMEOUT`, 255: response watchdog limit in cycles; only used with `IOB_DBUS_BRIDGE_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `iob_req`  in  1+ADDR_W+DATA_W+DATA_W/8  request bundle. Fields from MSB down: `valid`, `addr`, `wdata`, `wstrb`.
- `iob_resp`  out  DATA_W+1  response bundle `{rdata, ready}`, with `ready` at bit 0.
- `dbus_cmd_valid`  out  1  command valid.
- `dbus_cmd_ready`  in  1  command accepted.
- `dbus_cmd_wr`  out  1  1 = write.
- `dbus_cmd_address`  out  ADDR_W  byte address.
- `dbus_cmd_data`  out  DATA_W  write data.
- `dbus_cmd_mask`  out  DATA_W/8  byte mask.
- `dbus_cmd_size`  out  2  log2 of bytes.
- `dbus_rsp_valid`  in  1  read response valid.
- `dbus_rsp_data`  in  DATA_W  read data.
- `dbus_rsp_error`  in  1  response error.
- `err`  out  1  sticky error flag.

## Operation
- An IOb request with `wstrb != 0` is a write; `wstrb == 0` is a read.
- FSM states are IDLE, CMD, RSP and DONE.
- **IDLE**
  - When `valid=1`, capture `addr`, `wdata` and `wstrb` into registers and go to CMD.
- **CMD**
  - Drive `dbus_cmd_valid=1` with the registered fields. All fields stay stable until `dbus_cmd_ready`.
  - When `dbus_cmd_ready=1`: a write goes to DONE; a read goes to RSP.
- **RSP**
  - When `dbus_rsp_valid=1`, capture `dbus_rsp_data` into `rdata` and go to DONE.
  - If `dbus_rsp_error=1` in that cycle, also set `err`.
- **DONE**
  - `ready=1` for exactly this one cycle, then go to IDLE.
  - `iob_req.valid` is ignored in DONE, because the initiator still holds the old request.
- **Command field rules**
  - Read: `dbus_cmd_mask` is all-ones and `dbus_cmd_size=2`.
  - Write: `dbus_cmd_mask=wstrb`. `dbus_cmd_size` is 0 for a single strobe bit, 1 for two bits, 2 otherwise.
  - `dbus_cmd_address` is `addr` unmodified.
- **Response register**
  - `rdata` holds its last value outside DONE.
  - For writes, `rdata` is left unchanged.
- **Stray responses**
  - `dbus_rsp_valid` outside RSP is ignored and does not change `rdata`.
- **Error flag**
  - `err` is sticky and cleared only by `rst`.
- **Reset**
  - Asserting `rst` mid-transaction forces IDLE immediately and aborts any outstanding cmd/rsp.
  - All outputs are 0 after reset: `dbus_cmd_*`, `iob_resp` and `err`.

## Timing
- `dbus_cmd_valid` rises the cycle after `valid` is sampled in IDLE.
- Minimum write latency is 2 cycles from `valid` to `ready`, with `cmd_ready` high in the first CMD cycle.
- Minimum read latency is 3 cycles, with `rsp_valid` high in the first RSP cycle.
- A response arriving in the same cycle as command acceptance is not supported; the slave responds at least one cycle later.
- Back-to-back throughput: a new request is accepted in IDLE, the cycle after DONE.
- All outputs are registered or decoded from state only. There is no combinational path from `dbus_*` inputs to `iob_resp`.

## Configuration
- **`IOB_DBUS_BRIDGE_TIMEOUT_EN` defined**
  - A counter runs while in RSP.
  - When it reaches `TIMEOUT` with no `rsp_valid`: go to DONE with `rdata=DATA_W'hDEADBEEF` (low `DATA_W` bits), set `err`, and set a `stale` flag.
  - While `stale=1`, the next `dbus_rsp_valid` received in any state is discarded and clears `stale`.
  - The counter clears on entry to RSP.
- **Not defined**
  - No counter and no `stale` flag; RSP waits indefinitely.
  - `err` is set only by `dbus_rsp_error`.

## Test plan
- **Write word:** `valid`, `addr=0x100`, `wdata=0x12345678`, `wstrb=4'hF`, and slave `cmd_ready` immediate. Expect `cmd_wr=1`, `mask=F`, `size=2`, and `ready` pulsing 2 cycles after `valid`, exactly one cycle wide.
- **Byte write:** `wstrb=4'h4`, `addr=0x102`. Expect `mask=4`, `size=0`.
  - Then halfword write `wstrb=4'hC`. Expect `size=1`.
- **Read with backpressure:** hold `cmd_ready=0` for 3 cycles, then `rsp_valid` 2 cycles after accept with data `0xCAFEF00D`. Expect fields stable while stalled and `rdata=0xCAFEF00D` with `ready` for one cycle.
- **Held valid:** initiator keeps `valid=1` through DONE. Expect no duplicate command. A second request issued the cycle after DONE is accepted normally.
- **Error response:** read returns `rsp_error=1`. Expect `err=1`, which persists through later good transactions until `rst`.
- **Timeout (macro on, `TIMEOUT=8`):** read with no response. Expect `ready` with `rdata=0xDEADBEEF` and `err=1`. A late `rsp_valid` is discarded; the next read returns its own data correctly.
- **Mid-transaction reset:** assert `rst` while in RSP. Expect all outputs 0 and the FSM in IDLE.
